// File: rtl/button_pkg.sv
// button_pkg: shared event-FSM state encoding and ms-to-cycles conversion
package button_pkg;
   typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
   function automatic int ms_to_cyc(input int clk_hz, input int ms);
      return clk_hz / 1000 * ms;
   endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer, polarity normalisation and counter debounce with edge strobes
module button_debounce #(
   parameter int DB_CYC = 10,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam int CW = $clog2(DB_CYC + 1);
   logic s1, s2, pressed, differ, hit;
   logic [CW-1:0] cnt;
   assign pressed = s2 ^ ACTIVE_LOW;
   assign differ = pressed != level;
   assign hit = differ && (cnt == CW'(DB_CYC - 1));
   // sync raw pin, count disagreeing cycles, flip level once the count is reached
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= ACTIVE_LOW;
         s2 <= ACTIVE_LOW;
         cnt <= '0;
         level <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         cnt <= (differ && !hit) ? cnt + 1'b1 : '0;
         level <= level ^ hit;
         rise <= hit && !level;
         fall <= hit && level;
      end
   end
endmodule

// File: rtl/button_events.sv
// button_events: debounced button with press/release/long/auto-repeat strobes (repeat under BUTTON_EVENTS_REPEAT_EN)
module button_events import button_pkg::*; #(
   parameter int CLK_HZ = 25000000,
   parameter int DEBOUNCE_MS = 10,
   parameter int LONG_MS = 1000,
   parameter bit ACTIVE_LOW = 1'b1,
   parameter int REPEAT_MS = 200
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);
   localparam int DB_CYC = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
   localparam int LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);
`ifdef BUTTON_EVENTS_REPEAT_EN
   localparam int REP_CYC = ms_to_cyc(CLK_HZ, REPEAT_MS);
   localparam int HMAX = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
`else
   localparam int HMAX = LONG_CYC;
`endif
   localparam int HW = $clog2(HMAX + 1);

   if (CLK_HZ % 1000 != 0 || DEBOUNCE_MS < 1 || LONG_MS < 1 || REPEAT_MS < 1) begin : g_bad_params
      $error("button_events: illegal parameter set");
   end

   state_t state, nstate;
   logic [HW-1:0] hcnt, nhcnt;
   logic rise, fall;

   button_debounce #(.DB_CYC(DB_CYC), .ACTIVE_LOW(ACTIVE_LOW)) u_db (
      .clk(clk), .rst(rst), .raw(btn_in), .level(btn_level), .rise(rise), .fall(fall)
   );

   assign press_pulse = rise;
   assign release_pulse = fall;
`ifndef BUTTON_EVENTS_REPEAT_EN
   assign repeat_pulse = 1'b0;
`endif

   // event state and hold counter (hcnt = cycles since press_pulse while HELD)
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         hcnt <= '0;
      end else begin
         state <= nstate;
         hcnt <= nhcnt;
      end
   end

   // next state and strobes; a release always beats a coincident long/repeat
   always_comb begin
      nstate = state;
      nhcnt = hcnt;
      long_pulse = 1'b0;
`ifdef BUTTON_EVENTS_REPEAT_EN
      repeat_pulse = 1'b0;
`endif
      case (state)
         IDLE: if (rise) begin
            nstate = HELD;
            nhcnt = HW'(1);
         end
         HELD: if (fall) begin
            nstate = IDLE;
            nhcnt = '0;
         end else if (hcnt == HW'(LONG_CYC)) begin
            long_pulse = 1'b1;
            nstate = LONG;
`ifdef BUTTON_EVENTS_REPEAT_EN
            nhcnt = HW'(1);
`endif
         end else begin
            nhcnt = hcnt + 1'b1;
         end
         LONG: if (fall) begin
            nstate = IDLE;
            nhcnt = '0;
         end
`ifdef BUTTON_EVENTS_REPEAT_EN
         else if (hcnt == HW'(REP_CYC)) begin
            repeat_pulse = 1'b1;
            nhcnt = HW'(1);
         end else begin
            nhcnt = hcnt + 1'b1;
         end
`endif
         default: nstate = IDLE;
      endcase
   end
endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed checks of debounce latency, glitch rejection, long/repeat timing, reset and release race
module tb_button_events;
   logic clk = 1'b0, rst = 1'b1, btn_in = 1'b1;
   logic btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
   int cyc = 0, n_checks = 0, n_fail = 0;
   int n_press = 0, n_rel = 0, n_long = 0, n_rep = 0;
   int press_cyc = 0, rel_cyc = 0, long_cyc = 0, rep_first = 0, rep_last = 0;
   int t, snap, lsnap, rsnap;

   button_events #(.CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .ACTIVE_LOW(1'b1), .REPEAT_MS(5)) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level), .press_pulse(press_pulse),
      .release_pulse(release_pulse), .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
   );

   always #5 clk = ~clk;

   // cycle number of the most recent rising edge
   always @(posedge clk) cyc <= cyc + 1;

   // record when each strobe was seen
   always @(negedge clk) begin
      if (!rst) begin
         if (press_pulse) begin
            n_press <= n_press + 1;
            press_cyc <= cyc;
         end
         if (release_pulse) begin
            n_rel <= n_rel + 1;
            rel_cyc <= cyc;
         end
         if (long_pulse) begin
            n_long <= n_long + 1;
            long_cyc <= cyc;
         end
         if (repeat_pulse) begin
            n_rep <= n_rep + 1;
            rep_last <= cyc;
            if (n_rep == 0) rep_first <= cyc;
         end
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      wait_n(3);
      check("rst_outputs", {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse}, 0);
      rst = 1'b0;
      wait_n(10);
      check("idle_level", btn_level, 0);
      check("idle_press", n_press, 0);
      for (int i = 0; i < 10; i++) begin
         btn_in = 1'b0;
         wait_n(3);
         btn_in = 1'b1;
         wait_n(1);
      end
      wait_n(10);
      check("glitch_level", btn_level, 0);
      check("glitch_press", n_press, 0);
      check("glitch_release", n_rel, 0);
      t = cyc;
      btn_in = 1'b0;
      wait_n(8);
      check("press_latency", press_cyc - t, 6);
      check("press_count", n_press, 1);
      check("press_level", btn_level, 1);
      wait_n(60);
      check("long_count", n_long, 1);
      check("long_latency", long_cyc - press_cyc, 20);
`ifdef BUTTON_EVENTS_REPEAT_EN
      check("repeat_count", n_rep, 8);
      check("repeat_first", rep_first - long_cyc, 5);
      check("repeat_last", rep_last - long_cyc, 40);
`else
      check("repeat_count", n_rep, 0);
`endif
      t = cyc;
      btn_in = 1'b1;
      wait_n(8);
      check("release_latency", rel_cyc - t, 6);
      check("release_count", n_rel, 1);
      check("release_level", btn_level, 0);
      snap = n_rep;
      wait_n(20);
      check("repeat_stop", n_rep, snap);
      check("long_once", n_long, 1);
      btn_in = 1'b0;
      wait_n(33);
      check("long_before_reset", n_long, 2);
      lsnap = n_long;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_n(1);
         check("reset_outputs", {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse}, 0);
      end
      rst = 1'b0;
      t = cyc;
      wait_n(8);
      check("rst_press_latency", press_cyc - t, 6);
      check("rst_press_level", btn_level, 1);
      wait_n(15);
      check("no_early_long", n_long, lsnap);
      wait_n(8);
      check("rst_long_count", n_long, lsnap + 1);
      check("rst_long_latency", long_cyc - press_cyc, 20);
      btn_in = 1'b1;
      wait_n(10);
      check("rst_release_level", btn_level, 0);
      t = cyc;
      btn_in = 1'b0;
      wait_n(8);
      check("race_press_latency", press_cyc - t, 6);
      lsnap = n_long;
      rsnap = n_rel;
      wait_n(12);
      btn_in = 1'b1;
      wait_n(10);
      check("race_release_at", rel_cyc - press_cyc, 20);
      check("race_release_count", n_rel, rsnap + 1);
      check("race_no_long", n_long, lsnap);
      check("race_level", btn_level, 0);
      wait_n(30);
      check("race_no_late_long", n_long, lsnap);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
